shared_mem_arb: RTL

Parametrised N-channel shared memory model for core benches and small SoC tops. It serves NCH independent ncs/nwe request channels (instruction, data, DMA, …) from one single-ported word array. A round-robin arbiter and a programmable wait-state counter generate real per-channel back-pressure on `*_stall`, replacing always-ready memory stubs.

---
 rtl/shared_mem_arb_pkg.sv | 26 ++
 rtl/shared_mem_arb_rr_arbiter.sv | 32 +++
 rtl/shared_mem_arb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_arb_pkg.sv
// Shared types and sizing helpers for the shared_mem_arb multi-channel memory model.
package shared_mem_arb_pkg;

    localparam int MAX_NCH = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_e;

    // Byte-offset bits below the word index.
    function automatic int ofs_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_bits(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/shared_mem_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, scanning cyclically.
module rr_arbiter
    import shared_mem_arb_pkg::*;
#(
    parameter int NCH = 2,
    parameter int PW  = ptr_bits(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt_oh,
    output logic [PW-1:0]  gnt_idx,
    output logic           gnt_any
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = PW'((int'(ptr) + i) % NCH);
            if (!gnt_any && req[cand]) begin
                gnt_any      = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arb.sv
// N-channel single-ported memory with round-robin arbitration and programmable wait states.
// Optional range checking is enabled by defining SHARED_MEM_ARB_RANGE_CHK_EN.
module shared_mem_arb
    import shared_mem_arb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int WAIT       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             ch_ncs,
    input  logic [NCH-1:0]             ch_nwe,
    input  logic [NCH*ADDR_WIDTH-1:0]  ch_addr,
    input  logic [NCH*DATA_WIDTH-1:0]  ch_wdata,
    input  logic [NCH*DATA_WIDTH-1:0]  ch_wmask,
    output logic [NCH*DATA_WIDTH-1:0]  ch_rdata,
    output logic [NCH-1:0]             ch_stall,
    output logic [NCH-1:0]             ch_err
);

    localparam int OFS  = ofs_bits(DATA_WIDTH);
    localparam int IDXW = idx_bits(DEPTH);
    localparam int PW   = ptr_bits(NCH);

    state_e                    state_q, state_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]             gnt_q, gnt_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      nwe_q, nwe_d;
    logic                      oor_q, oor_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     wmask_q, wmask_d;
    logic [NCH*DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    logic [NCH-1:0]            arb_req, arb_oh;
    logic [PW-1:0]             arb_idx;
    logic                      arb_any;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [IDXW-1:0]           sel_idx;
    logic                      sel_oor;
    logic                      rd_load;
    logic [PW-1:0]             rd_ch;
    logic [IDXW-1:0]           rd_idx;
    logic                      rd_oor;
    logic                      unused_ok;

    assign arb_req = ~ch_ncs;

    rr_arbiter #(
        .NCH (NCH),
        .PW  (PW)
    ) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign sel_addr  = ch_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_idx   = sel_addr[OFS +: IDXW];
    assign unused_ok = ^{arb_oh, sel_addr};

`ifdef SHARED_MEM_ARB_RANGE_CHK_EN
    assign sel_oor = |(sel_addr >> (OFS + IDXW));
`else
    assign sel_oor = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        nwe_d    = nwe_q;
        oor_d    = oor_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rd_load  = 1'b0;
        rd_ch    = gnt_q;
        rd_idx   = idx_q;
        rd_oor   = oor_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_idx;
                    nwe_d   = ch_nwe[arb_idx];
                    oor_d   = sel_oor;
                    idx_d   = sel_idx;
                    wdata_d = ch_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wmask_d = ch_wmask[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    if (WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT);
                    end else begin
                        // No wait states: read data must come straight from the live request.
                        state_d = S_ACCESS;
                        rd_load = ch_nwe[arb_idx];
                        rd_ch   = arb_idx;
                        rd_idx  = sel_idx;
                        rd_oor  = sel_oor;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    rd_load = nwe_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                state_d  = S_IDLE;
                rr_ptr_d = (gnt_q == PW'(NCH - 1)) ? '0 : gnt_q + PW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) begin
            rdata_d[int'(rd_ch)*DATA_WIDTH +: DATA_WIDTH] = rd_oor ? '0 : mem[rd_idx];
        end
    end

    always_comb begin
        ch_stall = '0;
        ch_err   = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_stall[c] = !ch_ncs[c] && !(state_q == S_ACCESS && gnt_q == PW'(c));
`ifdef SHARED_MEM_ARB_RANGE_CHK_EN
            ch_err[c]   = (state_q == S_ACCESS) && (gnt_q == PW'(c)) && oor_q;
`endif
        end
    end

    assign ch_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            nwe_q    <= 1'b1;
            oor_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            nwe_q    <= nwe_d;
            oor_q    <= oor_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // Array has no reset so its contents survive rst; the write lands at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && !nwe_q && !oor_q) begin
            mem[idx_q] <= (mem[idx_q] & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

endmodule
